// File: rtl/btb_predictor_2bit.sv
// rtl/btb_predictor_2bit.sv - direct-mapped branch target buffer with saturating direction counters
// Combinational fetch lookup, Execute-stage update, and saturating resolved/mispredict statistics.
module btb_predictor_2bit #(
    parameter int ENTRY_BITS = 4,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] PC_F,
    output logic        PrPCSrc_F,
    output logic [31:0] PrALUResult_F,
    output logic        PrHit_F,
    input  logic        Update_E,
    input  logic [31:0] PC_E,
    input  logic        PCSrc_E,
    input  logic [31:0] ALUResult_E,
    input  logic        Mispredict_E,
    input  logic        Clear,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_LO  = ENTRY_BITS + 2;
    localparam int TAG_HI  = ENTRY_BITS + TAG_BITS + 1;

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispred_count;

    logic [ENTRY_BITS-1:0] w_f_idx;
    logic [TAG_BITS-1:0]   w_f_tag;
    logic [ENTRY_BITS-1:0] w_e_idx;
    logic [TAG_BITS-1:0]   w_e_tag;
    logic                  w_e_hit;
    logic                  w_f_taken;
    logic                  w_unused_pc;

    assign w_f_idx = PC_F[ENTRY_BITS+1:2];
    assign w_f_tag = PC_F[TAG_HI:TAG_LO];
    assign w_e_idx = PC_E[ENTRY_BITS+1:2];
    assign w_e_tag = PC_E[TAG_HI:TAG_LO];

    // Byte-offset and above-tag PC bits take no part in indexing or matching.
    assign w_unused_pc = ^{PC_F, PC_E};

    assign PrHit_F       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken     = PrHit_F && r_ctr[w_f_idx][CTR_BITS-1];
    assign PrPCSrc_F     = w_f_taken;
    assign PrALUResult_F = w_f_taken ? r_target[w_f_idx] : (PC_F + 32'd4);

    assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

    assign BranchCount  = r_branch_count;
    assign MispredCount = r_mispred_count;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_valid         <= '0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else begin
            if (Update_E) begin
                if (r_branch_count != 32'hFFFF_FFFF) begin
                    r_branch_count <= r_branch_count + 32'd1;
                end
                if (Mispredict_E && (r_mispred_count != 32'hFFFF_FFFF)) begin
                    r_mispred_count <= r_mispred_count + 32'd1;
                end
            end

            // Clear wins over a same-cycle update; statistics above still count it.
            if (Clear) begin
                r_valid <= '0;
                for (int i = 0; i < ENTRIES; i++) begin
                    r_ctr[i] <= CTR_WNT;
                end
            end else if (Update_E) begin
                if (w_e_hit) begin
                    if (PCSrc_E) begin
                        r_target[w_e_idx] <= ALUResult_E;
                        if (r_ctr[w_e_idx] != CTR_MAX) begin
                            r_ctr[w_e_idx] <= r_ctr[w_e_idx] + CTR_BITS'(1);
                        end
                    end else if (r_ctr[w_e_idx] != CTR_MIN) begin
                        r_ctr[w_e_idx] <= r_ctr[w_e_idx] - CTR_BITS'(1);
                    end
                end else if (PCSrc_E) begin
                    r_valid[w_e_idx]  <= 1'b1;
                    r_tag[w_e_idx]    <= w_e_tag;
                    r_target[w_e_idx] <= ALUResult_E;
                    r_ctr[w_e_idx]    <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor_2bit.sv
// tb/tb_btb_predictor_2bit.sv - self-checking bench for btb_predictor_2bit
// Directed scenarios with literal expectations, then randomized traffic against a table model.
module tb_btb_predictor_2bit;

    localparam int EB   = 4;
    localparam int TB   = 8;
    localparam int CB   = 2;
    localparam int N    = 1 << EB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CWT  = 1 << (CB - 1);

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC_F = 32'h0;
    logic        PrPCSrc_F;
    logic [31:0] PrALUResult_F;
    logic        PrHit_F;
    logic        Update_E = 1'b0;
    logic [31:0] PC_E = 32'h0;
    logic        PCSrc_E = 1'b0;
    logic [31:0] ALUResult_E = 32'h0;
    logic        Mispredict_E = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    btb_predictor_2bit #(.ENTRY_BITS(EB), .TAG_BITS(TB), .CTR_BITS(CB)) dut (
        .CLK(CLK), .Reset(Reset), .PC_F(PC_F), .PrPCSrc_F(PrPCSrc_F),
        .PrALUResult_F(PrALUResult_F), .PrHit_F(PrHit_F), .Update_E(Update_E),
        .PC_E(PC_E), .PCSrc_E(PCSrc_E), .ALUResult_E(ALUResult_E),
        .Mispredict_E(Mispredict_E), .Clear(Clear), .BranchCount(BranchCount),
        .MispredCount(MispredCount)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Reference table: plain integers, counter treated as a bounded number.
    bit          m_valid  [N];
    int          m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    logic [31:0] m_bc = 32'h0;
    logic [31:0] m_mc = 32'h0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> (EB + 2)) % (1 << TB));
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = CWT - 1;
            end
            m_bc = 32'h0;
            m_mc = 32'h0;
        end else begin
            int  ei;
            bit  ehit;
            ei   = idx_of(PC_E);
            ehit = m_valid[ei] && (m_tag[ei] == tag_of(PC_E));
            if (Update_E) begin
                m_bc = sat_inc(m_bc);
                if (Mispredict_E) m_mc = sat_inc(m_mc);
            end
            if (Clear) begin
                for (int i = 0; i < N; i++) begin
                    m_valid[i] = 1'b0;
                    m_ctr[i]   = CWT - 1;
                end
            end else if (Update_E && ehit) begin
                if (PCSrc_E) begin
                    m_ctr[ei]    = (m_ctr[ei] < CMAX) ? m_ctr[ei] + 1 : CMAX;
                    m_target[ei] = ALUResult_E;
                end else begin
                    m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
                end
            end else if (Update_E && PCSrc_E) begin
                m_valid[ei]  = 1'b1;
                m_tag[ei]    = tag_of(PC_E);
                m_target[ei] = ALUResult_E;
                m_ctr[ei]    = CWT;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            int          fi;
            bit          ehit;
            bit          etaken;
            logic [31:0] ealu;
            fi     = idx_of(PC_F);
            ehit   = m_valid[fi] && (m_tag[fi] == tag_of(PC_F));
            etaken = ehit && (m_ctr[fi] >= CWT);
            ealu   = etaken ? m_target[fi] : PC_F + 32'd4;
            chk("model_hit", {31'b0, PrHit_F}, {31'b0, ehit});
            chk("model_taken", {31'b0, PrPCSrc_F}, {31'b0, etaken});
            chk("model_target", PrALUResult_F, ealu);
            chk("model_bcount", BranchCount, m_bc);
            chk("model_mcount", MispredCount, m_mc);
        end
    end

    task automatic drive(logic [31:0] pcf, logic upd, logic [31:0] pce, logic tk,
                         logic [31:0] tgt, logic mis, logic clr, logic rst);
        @(posedge CLK);
        #1;
        PC_F = pcf; Update_E = upd; PC_E = pce; PCSrc_E = tk;
        ALUResult_E = tgt; Mispredict_E = mis; Clear = clr; Reset = rst;
    endtask

    task automatic upd_at(logic [31:0] pc, logic tk, logic [31:0] tgt);
        drive(pc, 1'b1, pc, tk, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic look(logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
    endtask

    initial begin
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;

        look(32'h40);
        chk("reset_hit", {31'b0, PrHit_F}, 32'd0);
        chk("reset_taken", {31'b0, PrPCSrc_F}, 32'd0);
        chk("reset_target", PrALUResult_F, 32'h44);
        chk("reset_bcount", BranchCount, 32'd0);
        chk("reset_mcount", MispredCount, 32'd0);

        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        look(32'h40);
        chk("alloc_hit", {31'b0, PrHit_F}, 32'd1);
        chk("alloc_taken", {31'b0, PrPCSrc_F}, 32'd1);
        chk("alloc_target", PrALUResult_F, 32'h100);
        chk("alloc_bcount", BranchCount, 32'd1);
        chk("alloc_mcount", MispredCount, 32'd1);

        upd_at(32'h40, 1'b0, 32'h0);
        upd_at(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("walk_nt2_taken", {31'b0, PrPCSrc_F}, 32'd0);
        chk("walk_nt2_hit", {31'b0, PrHit_F}, 32'd1);
        chk("walk_nt2_target", PrALUResult_F, 32'h44);
        upd_at(32'h40, 1'b0, 32'h0);
        upd_at(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("walk_floor_t1", {31'b0, PrPCSrc_F}, 32'd0);
        upd_at(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("walk_t2_taken", {31'b0, PrPCSrc_F}, 32'd1);
        upd_at(32'h40, 1'b1, 32'h100);
        upd_at(32'h40, 1'b1, 32'h100);
        upd_at(32'h40, 1'b1, 32'h100);
        upd_at(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("walk_sat_nt1", {31'b0, PrPCSrc_F}, 32'd1);
        upd_at(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("walk_sat_nt2", {31'b0, PrPCSrc_F}, 32'd0);

        upd_at(32'h440, 1'b1, 32'h200);
        look(32'h40);
        chk("alias_old_hit", {31'b0, PrHit_F}, 32'd0);
        chk("alias_old_target", PrALUResult_F, 32'h44);
        look(32'h440);
        chk("alias_new_target", PrALUResult_F, 32'h200);

        upd_at(32'h80, 1'b1, 32'h300);
        @(negedge CLK);
        chk("same_cycle_hit", {31'b0, PrHit_F}, 32'd0);
        look(32'h80);
        chk("next_cycle_hit", {31'b0, PrHit_F}, 32'd1);

        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        look(32'h80);
        chk("clear_hit", {31'b0, PrHit_F}, 32'd0);
        chk("clear_bcount", BranchCount, 32'd14);

        look(32'hFFFF_FFFC);
        chk("wrap_target", PrALUResult_F, 32'h0);

        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
        look(32'h40);
        chk("rst_upd_hit", {31'b0, PrHit_F}, 32'd0);
        chk("rst_upd_bcount", BranchCount, 32'd0);

        @(posedge CLK);
        #1;
        dut.r_branch_count = 32'hFFFF_FFFF;
        m_bc = 32'hFFFF_FFFF;
        upd_at(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("sat_bcount", BranchCount, 32'hFFFF_FFFF);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] pf, pe;
            pf = ($urandom_range(0, 3) << (EB + 2)) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            pe = ($urandom_range(0, 3) << (EB + 2)) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) pf = $urandom;
            if ($urandom_range(0, 3) == 0) pe = pf;
            drive(pf, ($urandom_range(0, 9) < 6), pe, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) == 0));
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
